pwm_dimmer_multi: RTL and testbench
===================================

# pwm_dimmer_multi

Multi-channel LED PWM dimmer with debounced up/down push-buttons, hold-to-repeat, per-channel level storage and optional linear fade. It is the parametrised successor to the single-channel key-driven dimmer. It sits between the DE10-Lite KEY inputs and the Arduino-header LED outputs. The channel count, level count, PWM period and all button timings are set by parameters.

## Interface
- CHANNELS, 4: number of independent LED channels (1..16)
- LEVELS, 16: brightness levels per channel, 0..LEVELS-1 (2..256)
- PWM_PERIOD, 250000: PWM period in clock_50 cycles
- DEBOUNCE_CYCLES, 1000000: stable cycles required to accept a button edge (20 ms)
- REPEAT_DELAY, 25000000: hold time before auto-repeat starts (0.5 s)
- REPEAT_RATE, 5000000: cycles between auto-repeat steps (0.1 s)

Ports:
- clock_50  in  1  50 MHz system clock
- reset  in  1  asynchronous, active-low; all state cleared
- increaseDuty  in  1  KEY, active-low, asynchronous to clock_50; steps the selected level up
- decreaseDuty  in  1  KEY, active-low, asynchronous; steps the selected level down
- sel  in  CW=max(1,$clog2(CHANNELS))  channel receiving button steps; asynchronous, synchronised internally
- fade_en  in  1  1: actual level ramps toward target; 0: actual level jumps to target
- LED  out  CHANNELS  PWM outputs, active-high
- level_out  out  LW=$clog2(LEVELS)  target level of the synchronised sel channel

## Operation
- Input conditioning:
  - Each key passes through a 2-flop synchroniser, then a debounce counter.
  - The debounced state changes only after DEBOUNCE_CYCLES consecutive cycles at the new value.
  - sel and fade_en pass through 2-flop synchronisers.
- Button FSM, one instance per key. States: IDLE, FIRST, HOLD, REPEAT.
  - IDLE -> FIRST on debounced press. FIRST emits a one-cycle step pulse, then goes to HOLD.
  - HOLD counts REPEAT_DELAY cycles -> REPEAT.
  - REPEAT emits one step pulse every REPEAT_RATE cycles.
  - Debounced release from any state -> IDLE, with no pulse.
- Simultaneous buttons:
  - If both debounced keys are pressed in the same cycle, both step pulses are suppressed.
  - Both FSMs hold in IDLE until both keys are released.
- Target registers, one per channel, LW bits wide:
  - An up pulse increments target[sel_s], saturating at LEVELS-1.
  - A down pulse decrements target[sel_s], saturating at 0.
  - Unselected channels never change.
  - A sel change while a key is held redirects subsequent repeats to the new channel.
- PWM counter:
  - One shared counter, 0..PWM_PERIOD-1, wrapping to 0.
  - The last cycle of a period (count == PWM_PERIOD-1) is the "wrap".
- Actual registers, one per channel, updated only at wrap:
  - fade_en_s=1: actual moves ±1 toward target, or holds if equal.
  - fade_en_s=0: actual <= target.
  - Updating only at wrap keeps every period glitch-free.
- Duty:
  - STEP = PWM_PERIOD/(LEVELS-1), integer division.
  - LED[i] = (actual[i] == LEVELS-1) ? 1 : (count < actual[i]*STEP).
  - Level 0 means LED is constant 0. Level LEVELS-1 means LED is constant 1.
  - The compare product width is wide enough to hold PWM_PERIOD, so there is no overflow.
- LED is registered: each output is a flop driven from the compare.

## Timing
- Reset values:
  - LED=0 and level_out=0.
  - All target, actual, count, debounce, repeat and FSM state = 0/IDLE.
  - Synchronisers hold "released" (1).
- Reset mid-operation clears everything immediately, including a partial fade. The first period after reset release starts at count 0.
- Press latency:
  - First step pulse arrives 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after the key falls.
  - target updates on the next cycle.
  - level_out reflects the change 1 cycle after target.
- Repeat pulses:
  - First repeat pulse at REPEAT_DELAY cycles after the FIRST pulse.
  - Subsequent pulses every REPEAT_RATE cycles.
- A new target reaches LED no earlier than the next wrap plus 1 cycle.
- A full fade spans |target-actual| periods.
- A bounce shorter than DEBOUNCE_CYCLES produces no pulse.

## Structure
- Package dimmer_pkg holds:
  - the btn_state_t enum (IDLE/FIRST/HOLD/REPEAT);
  - the clog2-derived width helpers;
  - the default timing constants.
- Sub-module button_repeat holds the synchroniser, debounce and button FSM, and outputs a step pulse plus the debounced level. It is instantiated twice.
- The top holds the simultaneous-press lock, the target/actual arrays, the PWM counter and the compare.

## Test plan
All scenarios use bench parameters CHANNELS=2, LEVELS=4, PWM_PERIOD=30 (STEP=10), DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
1. Reset, then hold increaseDuty low 10 cycles with sel=0, fade_en=0 -> one pulse at cycle 7, target[0]=1, level_out=1; after the next wrap LED[0] is high 10 of 30 cycles and LED[1] stays 0.
2. Hold increaseDuty for 60 cycles -> pulses at t, t+20, t+28 (then saturation); target[0] goes 1,2,3 and stays 3; LED[0] becomes constant 1.
3. Glitch increaseDuty low for 3 cycles -> no pulse; target unchanged.
4. Press both keys together for 40 cycles -> no pulses; after release, press decreaseDuty -> exactly one down step.
5. fade_en=1, target[1] goes from 0 to 3 with sel=1 -> actual[1] reads 1, 2, 3 on three successive wraps; LED[1] duty reads 10/30, 20/30, then 30/30.
6. Assert reset mid-fade at actual=2 -> LED=0 and level_out=0 within one cycle; after release, all outputs stay 0 until a press.

Source files
------------

// File: rtl/dimmer_pkg.sv
// rtl/dimmer_pkg.sv - shared types, width helpers and default timing for the PWM dimmer
// Purpose: button FSM state type, clog2-based width helpers, default DE10-Lite timing constants.
// Ports: none (package).
package dimmer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        HOLD   = 2'd2,
        REPEAT = 2'd3
    } btn_state_t;

    localparam int DEF_CHANNELS        = 4;
    localparam int DEF_LEVELS          = 16;
    localparam int DEF_PWM_PERIOD      = 250000;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_RATE     = 5000000;

    // Width of an index over n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/button_repeat.sv
// rtl/button_repeat.sv - key synchroniser, debounce and hold-to-repeat step generator
// Purpose: turns one asynchronous active-low key into a debounced level and step pulses.
// Ports:
//   clock_50  - system clock
//   reset     - asynchronous active-low reset
//   i_key_n   - raw key, active-low, asynchronous
//   i_lock    - forces the FSM to IDLE (simultaneous-press lock from the top)
//   o_step    - one-cycle step pulse (first press and each auto-repeat)
//   o_pressed - debounced key level, 1 = pressed
module button_repeat
    import dimmer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clock_50,
    input  logic reset,
    input  logic i_key_n,
    input  logic i_lock,
    output logic o_step,
    output logic o_pressed
);

    localparam int DW   = cnt_width(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = cnt_width(RMAX);

    logic [1:0]    r_sync;
    logic          r_db_key;
    logic [DW-1:0] r_db_cnt;
    btn_state_t    r_state;
    logic [RW-1:0] r_rpt_cnt;
    logic          r_step;
    logic          w_pressed;

    // Debounced value flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            r_sync   <= 2'b11;
            r_db_key <= 1'b1;
            r_db_cnt <= '0;
        end else begin
            r_sync <= {r_sync[0], i_key_n};
            if (r_sync[1] == r_db_key) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                r_db_key <= r_sync[1];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_pressed = ~r_db_key;

    // r_rpt_cnt is set to 1 on every emitted pulse, so it reads k on the k-th cycle after it.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_step    <= 1'b0;
            r_rpt_cnt <= '0;
        end else if (!w_pressed || i_lock) begin
            r_state   <= IDLE;
            r_step    <= 1'b0;
            r_rpt_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state   <= FIRST;
                    r_step    <= 1'b1;
                    r_rpt_cnt <= RW'(1);
                end
                FIRST: begin
                    r_state   <= HOLD;
                    r_step    <= 1'b0;
                    r_rpt_cnt <= r_rpt_cnt + 1'b1;
                end
                HOLD: begin
                    if (r_rpt_cnt >= RW'(REPEAT_DELAY)) begin
                        r_state   <= REPEAT;
                        r_step    <= 1'b1;
                        r_rpt_cnt <= RW'(1);
                    end else begin
                        r_step    <= 1'b0;
                        r_rpt_cnt <= r_rpt_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (r_rpt_cnt >= RW'(REPEAT_RATE)) begin
                        r_step    <= 1'b1;
                        r_rpt_cnt <= RW'(1);
                    end else begin
                        r_step    <= 1'b0;
                        r_rpt_cnt <= r_rpt_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_step    <= 1'b0;
                    r_rpt_cnt <= '0;
                end
            endcase
        end
    end

    assign o_step    = r_step;
    assign o_pressed = w_pressed;

endmodule

// File: rtl/pwm_dimmer_multi.sv
// rtl/pwm_dimmer_multi.sv - multi-channel key-driven PWM LED dimmer with optional fade
// Purpose: per-channel target/actual brightness, shared PWM counter, registered LED compare.
// Ports:
//   clock_50     - 50 MHz system clock
//   reset        - asynchronous active-low reset
//   increaseDuty - KEY, active-low, steps the selected level up
//   decreaseDuty - KEY, active-low, steps the selected level down
//   sel          - channel receiving button steps (asynchronous)
//   fade_en      - 1: actual ramps one level per period toward target; 0: jumps
//   LED          - PWM outputs, active-high
//   level_out    - target level of the selected channel
module pwm_dimmer_multi
    import dimmer_pkg::*;
#(
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int LEVELS          = DEF_LEVELS,
    parameter int PWM_PERIOD      = DEF_PWM_PERIOD,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    localparam int CW             = idx_width(CHANNELS),
    localparam int LW             = $clog2(LEVELS)
) (
    input  logic                clock_50,
    input  logic                reset,
    input  logic                increaseDuty,
    input  logic                decreaseDuty,
    input  logic [CW-1:0]       sel,
    input  logic                fade_en,
    output logic [CHANNELS-1:0] LED,
    output logic [LW-1:0]       level_out
);

    localparam int PW   = cnt_width(PWM_PERIOD);
    localparam int STEP = PWM_PERIOD / (LEVELS - 1);

    logic [CW-1:0]       r_sel_m, r_sel_s;
    logic                r_fade_m, r_fade_s;
    logic                r_lock;
    logic [LW-1:0]       r_target [CHANNELS];
    logic [LW-1:0]       r_actual [CHANNELS];
    logic [PW-1:0]       r_count;
    logic [CHANNELS-1:0] r_led;
    logic [LW-1:0]       r_level;

    logic w_up_step, w_dn_step, w_up_p, w_dn_p, w_lock, w_wrap, w_sel_ok;

    button_repeat #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) u_btn_up (
        .clock_50 (clock_50),
        .reset    (reset),
        .i_key_n  (increaseDuty),
        .i_lock   (w_lock),
        .o_step   (w_up_step),
        .o_pressed(w_up_p)
    );

    button_repeat #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) u_btn_dn (
        .clock_50 (clock_50),
        .reset    (reset),
        .i_key_n  (decreaseDuty),
        .i_lock   (w_lock),
        .o_step   (w_dn_step),
        .o_pressed(w_dn_p)
    );

    // Lock engages the cycle both keys read pressed and holds until both are released.
    assign w_lock   = (w_up_p & w_dn_p) | r_lock;
    assign w_wrap   = (r_count == PW'(PWM_PERIOD - 1));
    // sel may encode channels that do not exist when CHANNELS is not a power of two.
    assign w_sel_ok = (int'(r_sel_s) < CHANNELS);

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            r_sel_m  <= '0;
            r_sel_s  <= '0;
            r_fade_m <= 1'b0;
            r_fade_s <= 1'b0;
            r_lock   <= 1'b0;
            r_count  <= '0;
            r_level  <= '0;
        end else begin
            r_sel_m  <= sel;
            r_sel_s  <= r_sel_m;
            r_fade_m <= fade_en;
            r_fade_s <= r_fade_m;
            if (w_up_p && w_dn_p)
                r_lock <= 1'b1;
            else if (!w_up_p && !w_dn_p)
                r_lock <= 1'b0;
            r_count <= w_wrap ? '0 : r_count + 1'b1;
            r_level <= w_sel_ok ? r_target[r_sel_s] : '0;
        end
    end

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++)
                r_target[i] <= '0;
        end else if (w_sel_ok) begin
            if (w_up_step && !w_dn_step && (r_target[r_sel_s] != LW'(LEVELS - 1)))
                r_target[r_sel_s] <= r_target[r_sel_s] + 1'b1;
            else if (w_dn_step && !w_up_step && (r_target[r_sel_s] != '0))
                r_target[r_sel_s] <= r_target[r_sel_s] - 1'b1;
        end
    end

    // actual only moves at the period boundary so every PWM period has a single duty.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_actual[i] <= '0;
                r_led[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_wrap) begin
                    if (!r_fade_s)
                        r_actual[i] <= r_target[i];
                    else if (r_actual[i] < r_target[i])
                        r_actual[i] <= r_actual[i] + 1'b1;
                    else if (r_actual[i] > r_target[i])
                        r_actual[i] <= r_actual[i] - 1'b1;
                end
                r_led[i] <= (r_actual[i] == LW'(LEVELS - 1)) ? 1'b1
                          : (r_count < (PW'(r_actual[i]) * PW'(STEP)));
            end
        end
    end

    assign LED       = r_led;
    assign level_out = r_level;

endmodule

// File: tb/tb_pwm_dimmer_multi.sv
// tb/tb_pwm_dimmer_multi.sv - randomized self-checking bench for pwm_dimmer_multi
module tb_pwm_dimmer_multi;

    localparam int C    = 2;
    localparam int L    = 4;
    localparam int P    = 30;
    localparam int DEB  = 4;
    localparam int RD   = 20;
    localparam int RR   = 8;
    localparam int STEP = P / (L - 1);

    logic       clock_50     = 1'b0;
    logic       reset        = 1'b0;
    logic       increaseDuty = 1'b1;
    logic       decreaseDuty = 1'b1;
    logic [0:0] sel          = 1'b0;
    logic       fade_en      = 1'b0;
    logic [1:0] LED;
    logic [1:0] level_out;

    int n_total = 0;
    int n_bad   = 0;

    pwm_dimmer_multi #(
        .CHANNELS(C), .LEVELS(L), .PWM_PERIOD(P),
        .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clock_50    (clock_50),
        .reset       (reset),
        .increaseDuty(increaseDuty),
        .decreaseDuty(decreaseDuty),
        .sel         (sel),
        .fade_en     (fade_en),
        .LED         (LED),
        .level_out   (level_out)
    );

    always #5 clock_50 = ~clock_50;

    // Reference model: state after the most recent clock edge.
    int m_hup[DEB+2], m_hdn[DEB+2];   // raw key history, [0] = newest sample
    bit m_dbu, m_dbd;                  // debounced, 1 = pressed
    bit m_rlock;
    bit m_actu, m_actd;                // a press is being serviced
    int m_stu, m_std;                  // edge of the first pulse of that press
    bit m_pu, m_pd;                    // step pulses
    int m_sel_d1, m_sels, m_fade_d1, m_fades;
    int m_tgt[C], m_act[C], m_led[C];
    int m_cnt, m_lvl, m_edge;

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < DEB + 2; k++) begin
            m_hup[k] = 1;
            m_hdn[k] = 1;
        end
        m_dbu = 0; m_dbd = 0; m_rlock = 0;
        m_actu = 0; m_actd = 0; m_stu = 0; m_std = 0; m_pu = 0; m_pd = 0;
        m_sel_d1 = 0; m_sels = 0; m_fade_d1 = 0; m_fades = 0;
        for (int i = 0; i < C; i++) begin
            m_tgt[i] = 0; m_act[i] = 0; m_led[i] = 0;
        end
        m_cnt = 0; m_lvl = 0; m_edge = 0;
    endtask

    // Debounced value: accepted once the DEB synchronised samples seen this edge all agree.
    function automatic bit settle(input int h[DEB+2], input bit cur);
        for (int k = 3; k < DEB + 2; k++)
            if (h[k] != h[2]) return cur;
        return (h[2] == 0);
    endfunction

    // Pulse rule for a held key: at d=0, d=RD, then every RR after that.
    function automatic bit pulse_at(input int d);
        return (d == 0) || (d == RD) || (d > RD && ((d - RD) % RR) == 0);
    endfunction

    task automatic model_step();
        bit wrap, lock, n_dbu, n_dbd, n_pu, n_pd, n_rlock;
        int n_tgt[C], n_act[C], n_led[C];
        int n_cnt, n_lvl;
        m_edge++;
        wrap  = (m_cnt == P - 1);
        n_cnt = wrap ? 0 : m_cnt + 1;
        for (int i = 0; i < C; i++) begin
            n_led[i] = (m_act[i] == L - 1) ? 1 : int'(m_cnt < m_act[i] * STEP);
            if (!wrap)          n_act[i] = m_act[i];
            else if (!m_fades)  n_act[i] = m_tgt[i];
            else if (m_act[i] < m_tgt[i]) n_act[i] = m_act[i] + 1;
            else if (m_act[i] > m_tgt[i]) n_act[i] = m_act[i] - 1;
            else                n_act[i] = m_act[i];
            n_tgt[i] = m_tgt[i];
        end
        if (m_pu && !m_pd && m_tgt[m_sels] < L - 1) n_tgt[m_sels] = m_tgt[m_sels] + 1;
        if (m_pd && !m_pu && m_tgt[m_sels] > 0)     n_tgt[m_sels] = m_tgt[m_sels] - 1;
        n_lvl = m_tgt[m_sels];

        for (int k = DEB + 1; k > 0; k--) begin
            m_hup[k] = m_hup[k-1];
            m_hdn[k] = m_hdn[k-1];
        end
        m_hup[0] = int'(increaseDuty);
        m_hdn[0] = int'(decreaseDuty);
        n_dbu = settle(m_hup, m_dbu);
        n_dbd = settle(m_hdn, m_dbd);

        lock = (m_dbu && m_dbd) || m_rlock;
        if (!m_dbu || lock) begin
            m_actu = 0; n_pu = 0;
        end else begin
            if (!m_actu) begin m_actu = 1; m_stu = m_edge; end
            n_pu = pulse_at(m_edge - m_stu);
        end
        if (!m_dbd || lock) begin
            m_actd = 0; n_pd = 0;
        end else begin
            if (!m_actd) begin m_actd = 1; m_std = m_edge; end
            n_pd = pulse_at(m_edge - m_std);
        end
        n_rlock = (m_dbu && m_dbd) ? 1 : ((!m_dbu && !m_dbd) ? 0 : m_rlock);

        m_sels = m_sel_d1;   m_sel_d1  = int'(sel);
        m_fades = m_fade_d1; m_fade_d1 = int'(fade_en);
        m_dbu = n_dbu; m_dbd = n_dbd; m_pu = n_pu; m_pd = n_pd; m_rlock = n_rlock;
        for (int i = 0; i < C; i++) begin
            m_tgt[i] = n_tgt[i]; m_act[i] = n_act[i]; m_led[i] = n_led[i];
        end
        m_cnt = n_cnt; m_lvl = n_lvl;
    endtask

    task automatic tick();
        @(posedge clock_50);
        if (reset) model_step();
        #1;
        check_val("led", int'(LED), m_led[1] * 2 + m_led[0]);
        check_val("level_out", int'(level_out), m_lvl);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic measure_duty(input string tag, input int ch, input int exp);
        int hi = 0;
        for (int k = 0; k < P; k++) begin
            tick();
            hi += int'(LED[ch]);
        end
        check_val(tag, hi, exp);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        model_reset();
        #1;
        check_val("rst_led", int'(LED), 0);
        check_val("rst_level", int'(level_out), 0);
        ticks(n);
        reset = 1'b1;
    endtask

    initial begin
        bit reached;
        int mode, len;
        model_reset();
        #2;
        check_val("por_led", int'(LED), 0);
        check_val("por_level", int'(level_out), 0);
        @(posedge clock_50);
        #1;
        reset = 1'b1;

        // 1: single press on channel 0, fade off
        increaseDuty = 1'b0;
        ticks(8);
        check_val("t1_level_c8", int'(level_out), 0);
        tick();
        check_val("t1_level_c9", int'(level_out), 1);
        tick();
        increaseDuty = 1'b1;
        ticks(60);
        measure_duty("t1_duty0", 0, 10);
        measure_duty("t1_duty1", 1, 0);

        // 2: hold for repeat up to saturation
        increaseDuty = 1'b0;
        ticks(60);
        increaseDuty = 1'b1;
        ticks(40);
        check_val("t2_level", int'(level_out), 3);
        measure_duty("t2_duty0", 0, 30);

        // 3: short glitch
        decreaseDuty = 1'b0;
        ticks(3);
        decreaseDuty = 1'b1;
        ticks(20);
        check_val("t3_level", int'(level_out), 3);

        // 4: both keys, then a single down press
        increaseDuty = 1'b0;
        decreaseDuty = 1'b0;
        ticks(40);
        increaseDuty = 1'b1;
        decreaseDuty = 1'b1;
        ticks(15);
        check_val("t4_level_both", int'(level_out), 3);
        decreaseDuty = 1'b0;
        ticks(10);
        decreaseDuty = 1'b1;
        ticks(15);
        check_val("t4_level_down", int'(level_out), 2);

        // 5: fade channel 1 from 0 to 3
        sel = 1'b1;
        fade_en = 1'b1;
        ticks(5);
        check_val("t5_level_sel1", int'(level_out), 0);
        increaseDuty = 1'b0;
        ticks(60);
        increaseDuty = 1'b1;
        ticks(120);
        check_val("t5_level", int'(level_out), 3);
        measure_duty("t5_duty1", 1, 30);

        // 6: reset in the middle of a downward fade
        decreaseDuty = 1'b0;
        reached = 0;
        for (int k = 0; k < 200 && !reached; k++) begin
            tick();
            if (m_act[1] == 2 && m_tgt[1] < 2) reached = 1;
        end
        check_val("t6_reach_mid_fade", int'(reached), 1);
        decreaseDuty = 1'b1;
        do_reset(3);
        ticks(40);
        check_val("t6_led_after", int'(LED), 0);
        check_val("t6_level_after", int'(level_out), 0);

        // Random phase
        for (int s = 0; s < 40; s++) begin
            mode = $urandom_range(0, 6);
            len  = $urandom_range(1, 70);
            sel  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) fade_en = ~fade_en;
            if (mode == 6) begin
                do_reset($urandom_range(1, 3));
                continue;
            end
            increaseDuty = !(mode == 1 || mode == 3);
            decreaseDuty = !(mode == 2 || mode == 3);
            for (int k = 0; k < len; k++) begin
                if (mode == 4) begin
                    increaseDuty = 1'($urandom_range(0, 1));
                    decreaseDuty = 1'($urandom_range(0, 1));
                end
                if (mode == 5 && $urandom_range(0, 15) == 0) sel = ~sel;
                tick();
            end
            increaseDuty = 1'b1;
            decreaseDuty = 1'b1;
            ticks($urandom_range(0, 20));
        end
        ticks(100);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
